// File: rtl/gated_counter.sv
// ---------------------------------------------------------------------------
// gated_counter
//   Free-running up-counter advanced by one on every rising clock edge that
//   samples `active` high. The count wraps modulo 2^WIDTH, and a one-cycle
//   `overflow` pulse accompanies the wrap from all-ones to zero.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//
// Ports
//   clk      : input  clock, all state changes on its rising edge
//   rst_n    : input  synchronous active-low reset (priority over active)
//   active   : input  count enable, sampled on each rising edge
//   counter  : output current count value (registered)
//   overflow : output high for exactly one cycle after a wrap (registered)
// ---------------------------------------------------------------------------
module gated_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    output logic [WIDTH-1:0] counter,
    output logic             overflow
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             overflow_r;

    logic [WIDTH-1:0] next_count_s;
    logic             carry_s;

    // Incrementer: the carry out of the WIDTH-bit add is exactly the wrap event.
    always_comb begin
        {carry_s, next_count_s} = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Control FSM plus count/overflow registers; reset wins over active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            count_r    <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (active) begin
                        // Entering COUNT increments on this same edge: no dead cycle.
                        state_r    <= COUNT;
                        count_r    <= next_count_s;
                        overflow_r <= carry_s;
                    end else begin
                        state_r    <= IDLE;
                        count_r    <= count_r;
                        overflow_r <= 1'b0;
                    end
                end
                COUNT: begin
                    if (active) begin
                        state_r    <= COUNT;
                        count_r    <= next_count_s;
                        overflow_r <= carry_s;
                    end else begin
                        // Holding, even at all-ones, never raises overflow.
                        state_r    <= IDLE;
                        count_r    <= count_r;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    count_r    <= count_r;
                    overflow_r <= 1'b0;
                end
            endcase
        end
    end

    assign counter  = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_gated_counter.sv
// ---------------------------------------------------------------------------
// tb_gated_counter
//   Scoreboard bench for gated_counter. The driver applies inputs on the
//   falling edge, advances an arithmetic reference model and pushes the
//   expected post-edge outputs into a queue. An independent monitor samples
//   the outputs 1 ns after every rising edge, pops and compares.
// ---------------------------------------------------------------------------
module tb_gated_counter;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        logic [W-1:0] cnt;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         active;
    logic [W-1:0] counter;
    logic         overflow;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    bit   model_ovf = 1'b0;
    bit   done = 1'b0;

    gated_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (active),
        .counter  (counter),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, update reference model, queue expectation.
    // check_hold: verify outputs are unchanged before the edge (sync reset).
    task automatic apply(input bit rst, input bit act, input bit check_hold);
        exp_t e;
        rst_n  = rst;
        active = act;
        if (check_hold) begin
            #1;
            n_vec++;
            if (counter !== model_cnt[W-1:0]) begin
                n_fail++;
                $display("FAIL hold_counter: got %0d expected %0d", counter, model_cnt);
            end
            n_vec++;
            if (overflow !== model_ovf) begin
                n_fail++;
                $display("FAIL hold_overflow: got %0b expected %0b", overflow, model_ovf);
            end
        end
        if (!rst) begin
            model_cnt = 0;
            model_ovf = 1'b0;
        end else if (act) begin
            model_ovf = (model_cnt == MAX);
            model_cnt = (model_cnt + 1) % (MAX + 1);
        end else begin
            model_ovf = 1'b0;
        end
        e.cnt = model_cnt[W-1:0];
        e.ovf = model_ovf;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expected response per rising edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (!done) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL queue_empty: got output %0d with no expectation", counter);
                end
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (counter !== e.cnt) begin
                    n_fail++;
                    $display("FAIL counter: got %0d expected %0d at %0t", counter, e.cnt, $time);
                end
                n_vec++;
                if (overflow !== e.ovf) begin
                    n_fail++;
                    $display("FAIL overflow: got %0b expected %0b at %0t", overflow, e.ovf, $time);
                end
            end
        end
    end

    // Driver: directed phases from the test plan followed by random traffic.
    initial begin
        // Reset held for two edges with active high, then release idle.
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        // Continuous count 1..10.
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b0);
        // Alternating enable, one toggle per 10 ns period.
        for (int i = 0; i < 10; i++) apply(1'b1, (i % 2) == 0, 1'b0);
        // Count up to all-ones, hold, wrap, continue.
        while (model_cnt != MAX) apply(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        // Mid-count reset at 0x7F, outputs must hold until the edge.
        while (model_cnt != 8'h7F) apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        // Reset coinciding with the wrap edge: no pulse.
        while (model_cnt != MAX) apply(1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0);
        // Randomized traffic, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(0, 31) != 0), $urandom_range(0, 3) != 0, 1'b0);
        end
        done = 1'b1;
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d leftover expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gated_counter.md
# gated_counter

Free-running up-counter gated by an enable input, with a wraparound flag. Each rising clock edge that samples `active` high advances the count by one. A one-cycle `overflow` pulse marks the wrap from all-ones back to zero. The block is a small standalone utility counter used for event or duty counting by surrounding control logic.

## Interface
- `WIDTH`, default 8: counter width in bits. Must be ≥ 2.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `active`  input  1: count enable, sampled on each rising `clk` edge.
- `counter`  output  WIDTH (8): current count value, registered.
- `overflow`  output  1: wrap flag, registered, high for one cycle after a wrap.

## Operation
- Two-state FSM, registered:
  - IDLE: not counting.
  - COUNT: counting.
- State is internal only; the outputs depend only on the sampled `active` and on `counter`.
- Transitions, evaluated at each rising edge when `rst_n` = 1:
  - IDLE, `active` = 1 → COUNT. Counter increments on this same edge.
  - IDLE, `active` = 0 → IDLE. Counter holds.
  - COUNT, `active` = 1 → COUNT. Counter increments.
  - COUNT, `active` = 0 → IDLE. Counter holds.
- Increment is modulo 2^WIDTH with an unsigned WIDTH-bit adder. The carry out is not stored beyond `overflow`.
- `overflow`:
  - Set to 1 on the edge where `counter` goes from 2^WIDTH−1 to 0.
  - Set to 0 on every other edge, including hold edges.
  - It is a pulse, not sticky.
- Holding at 2^WIDTH−1 with `active` = 0 does not raise `overflow`. The pulse occurs only on the actual wrap edge.
- No saturation: the counter keeps counting past the wrap (…, 254, 255, 0, 1, …).

## Timing
- Reset, when `rst_n` = 0 at a rising edge:
  - `counter` ← 0, `overflow` ← 0, state ← IDLE.
  - Reset has priority over `active`.
  - Outputs are undefined before the first clock edge with `rst_n` low.
- Reset mid-count:
  - Takes effect on the next rising edge only, because reset is synchronous.
  - Between the `rst_n` fall and that edge, the outputs keep their previous values.
- Latency:
  - `active` sampled high at edge N → `counter` shows the incremented value after edge N (one-cycle register latency).
  - `overflow` follows the same latency and is high in exactly the cycle where `counter` first reads 0 after a wrap.
- The first edge with `rst_n` = 1 and `active` = 1 counts. No dead cycle is inserted after reset release.
- Simultaneous events:
  - `active` = 1 on the wrap edge while `rst_n` = 0 → reset wins; `overflow` stays 0.
- `active` toggling every cycle → counter advances every other cycle. There is no penalty on the IDLE↔COUNT transitions.
- Throughput: one increment per clock maximum.
- No combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 for 2 edges with `active` = 1.
  - Response: `counter` = 0 and `overflow` = 0 throughout.
  - Release `rst_n` with `active` = 0 → `counter` stays 0.
- Continuous count:
  - Stimulus: `active` = 1 for 10 edges after reset.
  - Response: `counter` = 1, 2, …, 10 on consecutive cycles; `overflow` = 0.
- Alternating enable:
  - Stimulus: 10 ns clock period, `active` toggling every 10 ns so that edges sample 1, 0, 1, 0, ….
  - Response: `counter` steps 0, 1, 1, 2, 2, 3, …; it advances only on edges that sample 1.
- Wrap:
  - Stimulus: count to 255, hold 3 cycles with `active` = 0, then 1 edge with `active` = 1.
  - Response: `overflow` = 0 during the hold. After the edge, `counter` = 0 and `overflow` = 1. One edge later, `overflow` = 0 and `counter` = 1 if `active` is still 1.
- Mid-count reset:
  - Stimulus: at `counter` = 0x7F with `active` = 1, drive `rst_n` = 0 for one edge.
  - Response: `counter` = 0 and `overflow` = 0 after that edge; counting resumes from 1 on the next enabled edge.
- Reset on wrap edge:
  - Stimulus: at `counter` = 255 with `active` = 1, drive `rst_n` = 0.
  - Response: `counter` = 0 and `overflow` = 0 (no pulse).
